// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - FSM states, segment patterns and double-dabble helper for seg7_scan_driver
package seg7_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    // Active-low segment patterns, bit order g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-low seven-segment lookup
module seg7_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - binary-to-BCD conversion and multiplexed 7-segment scan; SEG7_BLANK_LEADING_ZERO_EN blanks leading zeros
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DATA_W      = 5,
    parameter int N_DIGITS    = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DATA_W-1:0]   value,
    output logic                busy,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [N_DIGITS-1:0] an
);

    localparam int BCD_W  = 4 * N_DIGITS;
    localparam int ITER_W = $clog2(DATA_W + 1);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    if ((10 ** N_DIGITS) <= (2 ** DATA_W - 1) || REFRESH_DIV < 2) begin : g_param_check
        $error("seg7_scan_driver: N_DIGITS too small for DATA_W or REFRESH_DIV < 2");
    end

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shift_reg;
    logic [BCD_W-1:0]    scratch, scratch_adj;
    logic [ITER_W-1:0]   iter;
    logic [BCD_W-1:0]    bcd_disp;
    logic [CNT_W-1:0]    refresh_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic [3:0]          cur_bcd;
    logic [6:0]          seg_dec;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (load) state_nxt = ST_CONVERT;
            ST_CONVERT: if (iter == ITER_W'(DATA_W - 1)) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < N_DIGITS; i++) begin
            scratch_adj[4*i +: 4] = dabble_adjust(scratch[4*i +: 4]);
        end
    end

    // bcd_disp only changes in DONE, so the display never shows a partial result
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            iter      <= '0;
            bcd_disp  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shift_reg <= value;
                        scratch   <= '0;
                        iter      <= '0;
                    end
                end
                ST_CONVERT: begin
                    {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
                    iter                 <= iter + 1'b1;
                end
                ST_DONE: bcd_disp <= scratch;
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign dp   = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_W'(N_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_bcd = '0;
        an      = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_bcd = bcd_disp[4*i +: 4];
                an[i]   = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .bcd (cur_bcd),
        .seg (seg_dec)
    );

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    logic lead_zero;

    // Blank when this digit and all more-significant digits are zero; digit 0 always shows
    always_comb begin
        lead_zero = 1'b0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) lead_zero = ((bcd_disp >> (4*i)) == '0);
        end
    end

    assign seg = lead_zero ? SEG_BLANK : seg_dec;
`else
    assign seg = seg_dec;
`endif

endmodule
